// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver.
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned VAL_W      = 6;
    localparam int unsigned SEG_W      = 8;

    // Active-high {g,f,e,d,c,b,a} patterns for decimal digits.
    localparam logic [6:0] SEG_P0 = 7'h3F;
    localparam logic [6:0] SEG_P1 = 7'h06;
    localparam logic [6:0] SEG_P2 = 7'h5B;
    localparam logic [6:0] SEG_P3 = 7'h4F;
    localparam logic [6:0] SEG_P4 = 7'h66;
    localparam logic [6:0] SEG_P5 = 7'h6D;
    localparam logic [6:0] SEG_P6 = 7'h7D;
    localparam logic [6:0] SEG_P7 = 7'h07;
    localparam logic [6:0] SEG_P8 = 7'h7F;
    localparam logic [6:0] SEG_P9 = 7'h6F;

    // Active-low pin patterns: dash (g only, dp off) and all-off.
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Digits carrying the minute/hour separator point.
    localparam logic [5:0] DP_DIGIT_MASK = 6'b010100;

endpackage

// File: rtl/seg_scan_drive_if.sv
// Digit values in from the time counter, display pins out to the board.
interface seg_scan_drive_if;
    import seg_pkg::*;

    logic [VAL_W-1:0]      op0;
    logic [VAL_W-1:0]      op1;
    logic [VAL_W-1:0]      op2;
    logic [VAL_W-1:0]      op3;
    logic [VAL_W-1:0]      op4;
    logic [VAL_W-1:0]      op5;
    logic [NUM_DIGITS-1:0] dig_sel;
    logic [SEG_W-1:0]      seg;

    modport master (
        output op0, op1, op2, op3, op4, op5,
        input  dig_sel, seg
    );

    modport slave (
        input  op0, op1, op2, op3, op4, op5,
        output dig_sel, seg
    );

endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder; out-of-range values show a dash.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [VAL_W-1:0] value,
    input  logic             dp,
    output logic [SEG_W-1:0] seg_c
);

    logic [6:0] pat;
    logic       valid;

    // Pattern lookup; anything above 9 is flagged invalid.
    always_comb begin
        pat   = 7'h00;
        valid = 1'b1;
        case (value)
            6'd0:    pat = SEG_P0;
            6'd1:    pat = SEG_P1;
            6'd2:    pat = SEG_P2;
            6'd3:    pat = SEG_P3;
            6'd4:    pat = SEG_P4;
            6'd5:    pat = SEG_P5;
            6'd6:    pat = SEG_P6;
            6'd7:    pat = SEG_P7;
            6'd8:    pat = SEG_P8;
            6'd9:    pat = SEG_P9;
            default: valid = 1'b0;
        endcase
    end

    // Dash suppresses the decimal point so it cannot be mistaken for a digit.
    assign seg_c = valid ? ~{dp, pat} : SEG_DASH;

endmodule

// File: rtl/seg_scan_drive.sv
// Six-digit common-anode scan driver with per-frame digit capture and blinking separators.
// Optional build macro SEG_LZB_EN blanks the hours-tens digit while it holds zero.
module seg_scan_drive
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 1,
    parameter int unsigned BLINK_HALF = 500
) (
    input  logic           clk1,
    input  logic           rst_n,
    seg_scan_drive_if.slave bus
);

    localparam int unsigned DIV_W = 8;
    localparam int unsigned BLK_W = 10;
    localparam int unsigned IDX_W = 3;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_HALF - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0]      div_cnt, div_nxt;
    logic [IDX_W-1:0]      idx, idx_nxt;
    logic                  started;
    logic                  frame_start;
    logic [VAL_W-1:0]      snap [NUM_DIGITS];
    logic [BLK_W-1:0]      blink_cnt, blink_cnt_nxt;
    logic                  blink, blink_nxt;
    logic [VAL_W-1:0]      disp_val;
    logic                  dp;
    logic                  blank;
    logic [SEG_W-1:0]      dec_seg;
    logic [SEG_W-1:0]      seg_nxt;
    logic [NUM_DIGITS-1:0] dig_sel_nxt;
    logic [NUM_DIGITS-1:0] dig_sel_q;
    logic [SEG_W-1:0]      seg_q;

    // Scan position for the coming edge; frame starts on the first edge and on 5->0.
    always_comb begin
        div_nxt     = div_cnt;
        idx_nxt     = idx;
        frame_start = 1'b0;
        if (!started) begin
            div_nxt     = '0;
            idx_nxt     = '0;
            frame_start = 1'b1;
        end else if (div_cnt == DIV_LAST) begin
            div_nxt = '0;
            if (idx == IDX_LAST) begin
                idx_nxt     = '0;
                frame_start = 1'b1;
            end else begin
                idx_nxt = idx + IDX_W'(1);
            end
        end else begin
            div_nxt = div_cnt + DIV_W'(1);
        end
    end

    // Free-running blink timer; the displayed dp follows the post-edge blink state.
    always_comb begin
        blink_nxt     = blink;
        blink_cnt_nxt = blink_cnt + BLK_W'(1);
        if (blink_cnt == BLINK_LAST) begin
            blink_cnt_nxt = '0;
            blink_nxt     = ~blink;
        end
    end

    // Digit value to show: live op0 on a frame start so capture and display agree.
    always_comb begin
        disp_val = '0;
        if (frame_start) begin
            disp_val = bus.op0;
        end else begin
            case (idx_nxt)
                3'd0:    disp_val = snap[0];
                3'd1:    disp_val = snap[1];
                3'd2:    disp_val = snap[2];
                3'd3:    disp_val = snap[3];
                3'd4:    disp_val = snap[4];
                3'd5:    disp_val = snap[5];
                default: disp_val = '0;
            endcase
        end
    end

    assign dp = blink_nxt & DP_DIGIT_MASK[idx_nxt];

    seg7_decode u_dec (
        .value (disp_val),
        .dp    (dp),
        .seg_c (dec_seg)
    );

    // Leading-zero blanking of the hours-tens digit.
`ifdef SEG_LZB_EN
    assign blank = (idx_nxt == IDX_LAST) && (disp_val == '0);
`else
    assign blank = 1'b0;
`endif

    assign seg_nxt     = blank ? SEG_BLANK : dec_seg;
    assign dig_sel_nxt = ~(NUM_DIGITS'(1) << idx_nxt);

    // Scan, snapshot, blink and output registers.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            idx       <= '0;
            started   <= 1'b0;
            blink_cnt <= '0;
            blink     <= 1'b0;
            dig_sel_q <= '1;
            seg_q     <= SEG_BLANK;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                snap[i] <= '0;
            end
        end else begin
            div_cnt   <= div_nxt;
            idx       <= idx_nxt;
            started   <= 1'b1;
            blink_cnt <= blink_cnt_nxt;
            blink     <= blink_nxt;
            dig_sel_q <= dig_sel_nxt;
            seg_q     <= seg_nxt;
            if (frame_start) begin
                snap[0] <= bus.op0;
                snap[1] <= bus.op1;
                snap[2] <= bus.op2;
                snap[3] <= bus.op3;
                snap[4] <= bus.op4;
                snap[5] <= bus.op5;
            end
        end
    end

    assign bus.dig_sel = dig_sel_q;
    assign bus.seg     = seg_q;

endmodule

// File: doc/seg_scan_drive.md
# seg_scan_drive

Multiplexed 7-segment display driver for the electronic clock. Consumes the six BCD clock digits (seconds, minutes, hours; 6 bits each) from the time counter. Scans a six-digit common-anode display on the 1 kHz system tick, with frame-coherent digit capture and a blinking separator decimal point. Sits directly downstream of the time counter and drives the board pins.

## Interface
- SCAN_DIV, 1: clk1 cycles each digit stays selected (1..255); frame = 6·SCAN_DIV cycles.
- BLINK_HALF, 500: clk1 cycles per blink half-period (1..1023); 500 gives 1 Hz.
- clk1  in  1  1 kHz system tick.
- rst_n  in  1  reset, asynchronous, active-low.
- op0  in  6  seconds units.
- op1  in  6  seconds tens.
- op2  in  6  minutes units.
- op3  in  6  minutes tens.
- op4  in  6  hours units.
- op5  in  6  hours tens.
- dig_sel  out  6  digit enables, active-low, one-hot-low; bit i selects digit i.
- seg  out  8  {dp,g,f,e,d,c,b,a}, active-low.

## Operation
- Reset values: dig_sel=6'b111111, seg=8'hFF, idx=0, div_cnt=0, snapshot=0, blink=0, started=0.
- Scan: div_cnt counts 0..SCAN_DIV-1. On wrap, idx advances 0→1→…→5→0.
- Frame start: the first clk1 edge after reset release (started=0→1), and every edge where idx goes 5→0.
  - On a frame-start edge, the snapshot registers load op0..op5.
  - The digit-0 output on that same edge decodes the op0 value being captured.
  - Inputs changing mid-frame never affect the current frame (no tearing).
- Decode, active-high pattern before inversion: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Values 10..63 display a dash (g only): seg=8'hBF with dp off.
  - seg = ~{dp, pattern}.
- Decimal point: lit only on digits 2 and 4 (minute/hour separators), and only while blink=1.
- Blink: counter 0..BLINK_HALF-1, free-running from reset; blink toggles on each wrap.
- Only the 6-bit inputs are interpreted; no arithmetic on digit values.

## Timing
- dig_sel and seg are registered and change on the same clk1 edge; no glitch between them.
- Digit i is selected for exactly SCAN_DIV cycles, in order 0..5.
- Latency from an op change to display: at most one frame plus SCAN_DIV cycles.
- First edge after reset release: dig_sel=6'b111110, seg shows the decode of op0.
- Blink: the first toggle to 1 occurs BLINK_HALF edges after reset release.
- Reset mid-scan: outputs go all-off immediately (asynchronous). The scan restarts at digit 0 with a fresh capture.

## Configuration
- SEG_LZB_EN, when defined: digit 5 (hours tens) is blanked (seg=8'hFF) while its snapshot value is 0. Other digits are unaffected, and dp rules are unchanged.
- When not defined: a hours-tens value of 0 displays as '0' (seg=8'hC0).

## Structure
- Package seg_pkg holds:
  - NUM_DIGITS=6;
  - the ten segment pattern constants and SEG_DASH, SEG_BLANK;
  - DP_DIGIT_MASK=6'b010100.
- Sub-module seg7_decode: combinational, 6-bit value plus dp in, 8-bit active-low seg out. Handles the dash for values ≥10.
- Top level holds the scan counter, idx, snapshot, blink counter, leading-zero blanking, and output registers.

## Test plan
- Reset, then op0..op5 = 3,2,1,0,9,1 with SCAN_DIV=1. Expect:
  - dig_sel sequence 111110, 111101, 111011, 110111, 101111, 011111, repeating;
  - seg C0-inverted patterns B0, A4, F9, C0, 90, F9 (dp off while blink=0).
- Change op0 from 3 to 7 while idx=2. Expect digit 0 to still show B0 until the next frame start, then F8.
- op3=12. Expect digit 3 to show 8'hBF (dash).
- BLINK_HALF=4. Check that blink rises after 4 edges, and that digits 2 and 4 then show dp cleared (seg bit7=0), e.g. '1' on digit 2 → 8'h79.
- op5=0:
  - with SEG_LZB_EN, digit 5 seg=8'hFF;
  - without it, seg=8'hC0.
- Assert rst_n low mid-frame at idx=3. Expect immediate dig_sel=6'b111111 and seg=8'hFF. After release, digit 0 is selected on the first edge with freshly captured op0.
